// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multicycle MIPS control FSM sequencing the PC/IR/DR/ALUOut datapath
//
// Purpose : Moore control unit for the 32-bit MIPS multicycle datapath. Decodes
//           the IR opcode/funct, steps through fetch/decode/execute/memory/
//           writeback states and drives every datapath mux and enable. Memory
//           states wait on MIO_ready; undecodable instructions pulse illegal.
//
// Ports   : clk           rising-edge system clock
//           reset         synchronous, active-high; all outputs forced to 0 while high
//           Inst[31:0]    IR contents (opcode [31:26], funct [5:0])
//           zero          ALU zero flag (branch resolved in datapath, unused here)
//           overflow      ALU signed overflow
//           MIO_ready     memory/IO ready, 0 stalls the current memory state
//           IorD, IRWrite, RegWrite, ALUSrcA, PCWrite         1-bit datapath controls
//           RegDst, MemtoReg, ALUSrcB, PCSource, Branch      2-bit datapath controls
//           ALU_operation[2:0]  010 ADD, 110 SUB, 000 AND, 001 OR, 011 XOR, 100 NOR, 111 SLT
//           MemRead, MemWrite   bus strobes
//           state[3:0]    current state code (debug)
//           illegal       one-cycle pulse in ID for an undecodable instruction
//           ovf_trap      overflow trap indication in RWB/IWB
//
// Config  : MC_CTRL_OVF_TRAP_EN - when defined, signed overflow of add/sub/addi
//           suppresses the register writeback and raises ovf_trap. When
//           undefined, ovf_trap is tied to 0 and overflow is ignored.

module mc_ctrl_fsm #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Inst,
    input  logic        zero,
    input  logic        overflow,
    input  logic        MIO_ready,
    output logic        IorD,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic        PCWrite,
    output logic [1:0]  RegDst,
    output logic [1:0]  MemtoReg,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSource,
    output logic [1:0]  Branch,
    output logic [2:0]  ALU_operation,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [3:0]  state,
    output logic        illegal,
    output logic        ovf_trap
);

    typedef enum logic [3:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_MA     = 4'd2,
        S_MRD    = 4'd3,
        S_LWB    = 4'd4,
        S_MWR    = 4'd5,
        S_REX    = 4'd6,
        S_RWB    = 4'd7,
        S_BR     = 4'd8,
        S_J      = 4'd9,
        S_JAL    = 4'd10,
        S_JR     = 4'd11,
        S_IEX    = 4'd12,
        S_IWB    = 4'd13,
        S_LUI    = 4'd14,
        S_UNUSED = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_XOR  = 3'b011;
    localparam logic [2:0] ALU_NOR  = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    state_t     r_state;
    state_t     w_next;
    state_t     w_id_next;
    logic       w_id_illegal;
    logic [5:0] w_opcode;
    logic [5:0] w_funct;
    logic [2:0] w_rex_op;
    logic       w_rex_ok;
    logic [2:0] w_iex_op;
    logic       w_ovf_set;

    assign w_opcode = Inst[31:26];
    assign w_funct  = Inst[5:0];

    // R-type ALU operation; w_rex_ok flags a funct we know how to execute.
    always_comb begin
        w_rex_op = ALU_ADD;
        w_rex_ok = 1'b1;
        case (w_funct)
            FN_ADD, FN_ADDU: w_rex_op = ALU_ADD;
            FN_SUB, FN_SUBU: w_rex_op = ALU_SUB;
            FN_AND:          w_rex_op = ALU_AND;
            FN_OR:           w_rex_op = ALU_OR;
            FN_XOR:          w_rex_op = ALU_XOR;
            FN_NOR:          w_rex_op = ALU_NOR;
            FN_SLT:          w_rex_op = ALU_SLT;
            default:         w_rex_ok = 1'b0;
        endcase
    end

    // Immediate ALU operation for IEX/IWB.
    always_comb begin
        w_iex_op = ALU_ADD;
        case (w_opcode)
            OP_SLTI: w_iex_op = ALU_SLT;
            OP_ANDI: w_iex_op = ALU_AND;
            OP_ORI:  w_iex_op = ALU_OR;
            OP_XORI: w_iex_op = ALU_XOR;
            default: w_iex_op = ALU_ADD;
        endcase
    end

    // Instruction dispatch out of ID.
    always_comb begin
        w_id_next    = S_IF;
        w_id_illegal = 1'b0;
        case (w_opcode)
            OP_LW, OP_SW: w_id_next = S_MA;
            OP_RTYPE: begin
                if (w_funct == FN_JR) begin
                    w_id_next = S_JR;
                end else if (w_rex_ok) begin
                    w_id_next = S_REX;
                end else begin
                    w_id_illegal = 1'b1;
                end
            end
            OP_BEQ, OP_BNE: w_id_next = S_BR;
            OP_J:           w_id_next = S_J;
            OP_JAL:         w_id_next = S_JAL;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: w_id_next = S_IEX;
            OP_LUI:         w_id_next = S_LUI;
            default:        w_id_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= state_t'(RESET_STATE);
        end else begin
            r_state <= w_next;
        end
    end

`ifdef MC_CTRL_OVF_TRAP_EN
    logic r_ovf;
    logic w_trapable_r;

    // addu/subu never trap, only the signed forms.
    assign w_trapable_r = (w_funct == FN_ADD) || (w_funct == FN_SUB);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (r_state == S_REX) begin
            r_ovf <= overflow & w_trapable_r;
        end else if (r_state == S_IEX) begin
            r_ovf <= overflow & (w_opcode == OP_ADDI);
        end else if (w_next == S_IF) begin
            r_ovf <= 1'b0;
        end
    end

    assign w_ovf_set = r_ovf;

    logic w_unused;
    assign w_unused = &{1'b0, zero, Inst[25:6]};
`else
    assign w_ovf_set = 1'b0;

    logic w_unused;
    assign w_unused = &{1'b0, zero, overflow, Inst[25:6]};
`endif

    always_comb begin
        w_next        = S_IF;
        IorD          = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        PCWrite       = 1'b0;
        RegDst        = 2'b00;
        MemtoReg      = 2'b00;
        ALUSrcB       = 2'b00;
        PCSource      = 2'b00;
        Branch        = 2'b00;
        ALU_operation = 3'b000;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        illegal       = 1'b0;
        ovf_trap      = 1'b0;
        state         = r_state;

        case (r_state)
            S_IF: begin
                // IRWrite/PCWrite stay high while stalled; the datapath gates PC on ready.
                MemRead       = 1'b1;
                IRWrite       = 1'b1;
                ALUSrcB       = 2'b01;
                ALU_operation = ALU_ADD;
                PCWrite       = 1'b1;
                w_next        = MIO_ready ? S_ID : S_IF;
            end
            S_ID: begin
                // ALUOut captures the branch target speculatively.
                ALUSrcB       = 2'b11;
                ALU_operation = ALU_ADD;
                illegal       = w_id_illegal;
                w_next        = w_id_next;
            end
            S_MA: begin
                ALUSrcA       = 1'b1;
                ALUSrcB       = 2'b10;
                ALU_operation = ALU_ADD;
                if (w_opcode == OP_LW) begin
                    w_next = S_MRD;
                end else if (w_opcode == OP_SW) begin
                    w_next = S_MWR;
                end else begin
                    w_next = S_IF;
                end
            end
            S_MRD: begin
                // Address computation held so ALUOut stays valid across stalls.
                ALUSrcA       = 1'b1;
                ALUSrcB       = 2'b10;
                ALU_operation = ALU_ADD;
                IorD          = 1'b1;
                MemRead       = 1'b1;
                w_next        = MIO_ready ? S_LWB : S_MRD;
            end
            S_LWB: begin
                MemtoReg = 2'b01;
                RegWrite = 1'b1;
                w_next   = S_IF;
            end
            S_MWR: begin
                ALUSrcA       = 1'b1;
                ALUSrcB       = 2'b10;
                ALU_operation = ALU_ADD;
                IorD          = 1'b1;
                MemWrite      = 1'b1;
                w_next        = MIO_ready ? S_IF : S_MWR;
            end
            S_REX: begin
                ALUSrcA       = 1'b1;
                ALU_operation = w_rex_op;
                w_next        = S_RWB;
            end
            S_RWB: begin
                RegDst        = 2'b01;
                RegWrite      = ~w_ovf_set;
                ovf_trap      = w_ovf_set;
                ALUSrcA       = 1'b1;
                ALU_operation = w_rex_op;
                w_next        = S_IF;
            end
            S_BR: begin
                ALUSrcA       = 1'b1;
                ALU_operation = ALU_SUB;
                PCSource      = 2'b01;
                Branch        = (w_opcode == OP_BNE) ? 2'b10 : 2'b01;
                w_next        = S_IF;
            end
            S_J: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
                w_next   = S_IF;
            end
            S_JAL: begin
                // PC still holds PC+4 here, so $ra and the jump share one edge.
                PCSource = 2'b10;
                PCWrite  = 1'b1;
                RegDst   = 2'b10;
                MemtoReg = 2'b11;
                RegWrite = 1'b1;
                w_next   = S_IF;
            end
            S_JR: begin
                // rs + $0 through the ALU yields the jump target directly.
                ALUSrcA       = 1'b1;
                ALU_operation = ALU_ADD;
                PCWrite       = 1'b1;
                w_next        = S_IF;
            end
            S_IEX: begin
                ALUSrcA       = 1'b1;
                ALUSrcB       = 2'b10;
                ALU_operation = w_iex_op;
                w_next        = S_IWB;
            end
            S_IWB: begin
                RegWrite      = ~w_ovf_set;
                ovf_trap      = w_ovf_set;
                ALUSrcA       = 1'b1;
                ALUSrcB       = 2'b10;
                ALU_operation = w_iex_op;
                w_next        = S_IF;
            end
            S_LUI: begin
                MemtoReg = 2'b10;
                RegWrite = 1'b1;
                w_next   = S_IF;
            end
            default: begin
                w_next = S_IF;
            end
        endcase

        // Reset silences every control at once so no write completes after it rises.
        if (reset) begin
            IorD          = 1'b0;
            IRWrite       = 1'b0;
            RegWrite      = 1'b0;
            ALUSrcA       = 1'b0;
            PCWrite       = 1'b0;
            RegDst        = 2'b00;
            MemtoReg      = 2'b00;
            ALUSrcB       = 2'b00;
            PCSource      = 2'b00;
            Branch        = 2'b00;
            ALU_operation = 3'b000;
            MemRead       = 1'b0;
            MemWrite      = 1'b0;
            illegal       = 1'b0;
            ovf_trap      = 1'b0;
            state         = 4'd0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - self-checking bench for mc_ctrl_fsm
module tb_mc_ctrl_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Inst;
    logic        zero;
    logic        overflow;
    logic        MIO_ready;
    logic        IorD, IRWrite, RegWrite, ALUSrcA, PCWrite;
    logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSource, Branch;
    logic [2:0]  ALU_operation;
    logic        MemRead, MemWrite;
    logic [3:0]  state;
    logic        illegal, ovf_trap;

    always #5 clk = ~clk;

    mc_ctrl_fsm dut (
        .clk(clk), .reset(reset), .Inst(Inst), .zero(zero), .overflow(overflow),
        .MIO_ready(MIO_ready), .IorD(IorD), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .PCWrite(PCWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .ALUSrcB(ALUSrcB), .PCSource(PCSource), .Branch(Branch),
        .ALU_operation(ALU_operation), .MemRead(MemRead), .MemWrite(MemWrite),
        .state(state), .illegal(illegal), .ovf_trap(ovf_trap)
    );

    typedef struct packed {
        logic       iord, irwrite, regwrite, srca, pcwrite;
        logic [1:0] regdst, memtoreg, srcb, pcsrc, branch;
        logic [2:0] alu;
        logic       memread, memwrite, ill, trap;
    } cw_t;

    localparam logic [2:0] A_AND = 3'b000, A_OR = 3'b001, A_ADD = 3'b010, A_XOR = 3'b011;
    localparam logic [2:0] A_NOR = 3'b100, A_SUB = 3'b110, A_SLT = 3'b111;

    logic [21:0] obs_cw;
    assign obs_cw = {IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, RegDst, MemtoReg, ALUSrcB,
                     PCSource, Branch, ALU_operation, MemRead, MemWrite, illegal, ovf_trap};

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] exp_st[$];
    logic       exp_rdy[$];
    cw_t        exp_cw[$];

    function automatic bit legal(input logic [31:0] inst);
        logic [5:0] op, fn;
        op = inst[31:26];
        fn = inst[5:0];
        if (op == 6'h00)
            return fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h08};
        return op inside {6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03, 6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h0f};
    endfunction

    function automatic logic [2:0] alu_of(input logic [31:0] inst);
        logic [5:0] op, fn;
        op = inst[31:26];
        fn = inst[5:0];
        if (op == 6'h00) begin
            case (fn)
                6'h20, 6'h21: return A_ADD;
                6'h22, 6'h23: return A_SUB;
                6'h24: return A_AND;
                6'h25: return A_OR;
                6'h26: return A_XOR;
                6'h27: return A_NOR;
                6'h2a: return A_SLT;
                default: return A_ADD;
            endcase
        end
        case (op)
            6'h0a: return A_SLT;
            6'h0c: return A_AND;
            6'h0d: return A_OR;
            6'h0e: return A_XOR;
            default: return A_ADD;
        endcase
    endfunction

    function automatic bit traps(input logic [31:0] inst, input bit ovf);
`ifdef MC_CTRL_OVF_TRAP_EN
        return ovf && ((inst[31:26] == 6'h00 && (inst[5:0] == 6'h20 || inst[5:0] == 6'h22))
                       || inst[31:26] == 6'h08);
`else
        return 1'b0;
`endif
    endfunction

    function automatic cw_t ctrl_for(input int st, input logic [31:0] inst, input bit trap);
        cw_t c;
        c = '0;
        case (st)
            0:  begin c.memread = 1; c.irwrite = 1; c.srcb = 2'b01; c.alu = A_ADD; c.pcwrite = 1; end
            1:  begin c.srcb = 2'b11; c.alu = A_ADD; c.ill = !legal(inst); end
            2:  begin c.srca = 1; c.srcb = 2'b10; c.alu = A_ADD; end
            3:  begin c.srca = 1; c.srcb = 2'b10; c.alu = A_ADD; c.iord = 1; c.memread = 1; end
            4:  begin c.memtoreg = 2'b01; c.regwrite = 1; end
            5:  begin c.srca = 1; c.srcb = 2'b10; c.alu = A_ADD; c.iord = 1; c.memwrite = 1; end
            6:  begin c.srca = 1; c.alu = alu_of(inst); end
            7:  begin c.regdst = 2'b01; c.regwrite = !trap; c.trap = trap; c.srca = 1; c.alu = alu_of(inst); end
            8:  begin c.srca = 1; c.alu = A_SUB; c.pcsrc = 2'b01;
                      c.branch = (inst[31:26] == 6'h04) ? 2'b01 : 2'b10; end
            9:  begin c.pcsrc = 2'b10; c.pcwrite = 1; end
            10: begin c.pcsrc = 2'b10; c.pcwrite = 1; c.regdst = 2'b10; c.memtoreg = 2'b11; c.regwrite = 1; end
            11: begin c.srca = 1; c.alu = A_ADD; c.pcwrite = 1; end
            12: begin c.srca = 1; c.srcb = 2'b10; c.alu = alu_of(inst); end
            13: begin c.regwrite = !trap; c.trap = trap; c.srca = 1; c.srcb = 2'b10; c.alu = alu_of(inst); end
            14: begin c.memtoreg = 2'b10; c.regwrite = 1; end
            default: ;
        endcase
        return c;
    endfunction

    // Expected state walk of one instruction, from IF up to (not including) the next IF.
    task automatic plan(input logic [31:0] inst, input bit ovf, input int if_stall, input int mem_stall);
        logic [5:0] op;
        int path[$];
        bit rdy[$];
        bit tr;
        op = inst[31:26];
        tr = traps(inst, ovf);
        exp_st.delete(); exp_rdy.delete(); exp_cw.delete();
        repeat (if_stall) begin path.push_back(0); rdy.push_back(0); end
        path.push_back(0); rdy.push_back(1);
        path.push_back(1); rdy.push_back($urandom_range(0, 1));
        if (legal(inst)) begin
            case (op)
                6'h23: begin
                    path.push_back(2); rdy.push_back($urandom_range(0, 1));
                    repeat (mem_stall) begin path.push_back(3); rdy.push_back(0); end
                    path.push_back(3); rdy.push_back(1);
                    path.push_back(4); rdy.push_back($urandom_range(0, 1));
                end
                6'h2b: begin
                    path.push_back(2); rdy.push_back($urandom_range(0, 1));
                    repeat (mem_stall) begin path.push_back(5); rdy.push_back(0); end
                    path.push_back(5); rdy.push_back(1);
                end
                6'h00: begin
                    if (inst[5:0] == 6'h08) begin path.push_back(11); rdy.push_back($urandom_range(0, 1)); end
                    else begin
                        path.push_back(6); rdy.push_back($urandom_range(0, 1));
                        path.push_back(7); rdy.push_back($urandom_range(0, 1));
                    end
                end
                6'h04, 6'h05: begin path.push_back(8); rdy.push_back($urandom_range(0, 1)); end
                6'h02: begin path.push_back(9); rdy.push_back($urandom_range(0, 1)); end
                6'h03: begin path.push_back(10); rdy.push_back($urandom_range(0, 1)); end
                6'h0f: begin path.push_back(14); rdy.push_back($urandom_range(0, 1)); end
                default: begin
                    path.push_back(12); rdy.push_back($urandom_range(0, 1));
                    path.push_back(13); rdy.push_back($urandom_range(0, 1));
                end
            endcase
        end
        foreach (path[k]) begin
            exp_st.push_back(4'(path[k]));
            exp_rdy.push_back(rdy[k]);
            exp_cw.push_back(ctrl_for(path[k], inst, tr));
        end
    endtask

    // Runs one instruction from IF; leaves the DUT entering the following IF.
    task automatic exec(input logic [31:0] inst, input bit ovf, input int if_stall,
                        input int mem_stall, input string tag);
        plan(inst, ovf, if_stall, mem_stall);
        for (int i = 0; i < exp_st.size(); i++) begin
            Inst      = inst;
            overflow  = ovf;
            MIO_ready = exp_rdy[i];
            zero      = 1'($urandom);
            @(negedge clk);
            n_cmp++;
            if (state !== exp_st[i] || obs_cw !== 22'(exp_cw[i])) begin
                n_bad++;
                $display("FAIL %s step %0d: state=%0d cw=%h, expected state=%0d cw=%h",
                         tag, i, state, obs_cw, exp_st[i], 22'(exp_cw[i]));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            Inst = $urandom; MIO_ready = 1'($urandom); overflow = 1'($urandom); zero = 1'($urandom);
            @(negedge clk);
            n_cmp++;
            if (state !== 4'd0 || obs_cw !== 22'd0) begin
                n_bad++;
                $display("FAIL reset_hold cyc %0d: state=%0d cw=%h, expected 0/0", i, state, obs_cw);
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
        Inst = 32'h0800_0010;
        MIO_ready = 1'b1;
        overflow = 1'b0;
        for (int i = 0; i < 3; i++) begin
            int st;
            st = (i == 0) ? 0 : (i == 1) ? 1 : 9;
            @(negedge clk);
            n_cmp++;
            if (state !== 4'(st) || obs_cw !== 22'(ctrl_for(st, Inst, 1'b0))) begin
                n_bad++;
                $display("FAIL reset_release cyc %0d: state=%0d cw=%h, expected state=%0d cw=%h",
                         i, state, obs_cw, st, 22'(ctrl_for(st, Inst, 1'b0)));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw_stall;
        exec({6'h23, 5'd1, 5'd2, 16'h0004}, 1'b0, 0, 3, "lw_stall");
        exec({6'h23, 5'd1, 5'd2, 16'h0008}, 1'b0, 2, 0, "lw_ifstall");
    endtask

    task automatic test_branch;
        exec({6'h04, 5'd1, 5'd2, 16'hFFFC}, 1'b0, 0, 0, "beq");
        exec({6'h05, 5'd1, 5'd2, 16'h0003}, 1'b0, 0, 0, "bne");
    endtask

    task automatic test_jumps;
        exec({6'h03, 26'h0000100}, 1'b0, 0, 0, "jal");
        exec({6'h00, 5'd31, 15'd0, 6'h08}, 1'b0, 0, 0, "jr");
        exec({6'h0f, 5'd0, 5'd4, 16'h1234}, 1'b0, 0, 0, "lui");
    endtask

    task automatic test_overflow;
        exec({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 1'b1, 0, 0, "add_ovf");
        exec({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, 1'b1, 0, 0, "addu_ovf");
        exec({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 1'b0, 0, 0, "add_clean");
        exec({6'h08, 5'd1, 5'd5, 16'h7FFF}, 1'b1, 0, 0, "addi_ovf");
        exec({6'h22 == 6'h22 ? 6'h00 : 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h22}, 1'b1, 0, 0, "sub_ovf");
    endtask

    task automatic test_illegal;
        exec(32'hFC00_0000, 1'b0, 0, 0, "illegal_op");
        exec({6'h00, 20'h0, 6'h3F}, 1'b0, 0, 0, "illegal_funct");
        exec({6'h02, 26'h0000040}, 1'b0, 0, 0, "after_illegal");
    endtask

    task automatic test_back_to_back;
        exec({6'h2b, 5'd1, 5'd2, 16'h0010}, 1'b0, 0, 2, "b2b_sw");
        exec({6'h0f, 5'd0, 5'd7, 16'hBEEF}, 1'b0, 0, 0, "b2b_lui");
        exec({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h27}, 1'b0, 0, 0, "b2b_nor");
        exec({6'h0a, 5'd1, 5'd2, 16'h0001}, 1'b0, 0, 0, "b2b_slti");
    endtask

    task automatic test_random;
        logic [5:0] ops[16] = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02,
                                6'h03, 6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h3F};
        logic [5:0] fns[12] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                6'h2a, 6'h08, 6'h01, 6'h3A};
        for (int n = 0; n < 60; n++) begin
            logic [5:0] op, fn;
            op = ops[$urandom_range(0, 15)];
            if (op == 6'h3F) op = 6'($urandom);
            fn = fns[$urandom_range(0, 11)];
            exec({op, 20'($urandom), fn}, 1'($urandom), $urandom_range(0, 2),
                 $urandom_range(0, 3), "random");
        end
    endtask

    task automatic test_reset_mid;
        Inst = {6'h23, 5'd1, 5'd2, 16'h0004};
        overflow = 1'b0;
        for (int i = 0; i < 4; i++) begin
            MIO_ready = (i < 3);
            @(negedge clk);
            if (i == 3) begin
                n_cmp++;
                if (state !== 4'd3) begin
                    n_bad++;
                    $display("FAIL reset_mid_pre: state=%0d, expected 3", state);
                end
            end
            @(posedge clk); #1;
        end
        reset = 1'b1;
        MIO_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (state !== 4'd0 || obs_cw !== 22'd0) begin
            n_bad++;
            $display("FAIL reset_mid_gate: state=%0d cw=%h, expected 0/0", state, obs_cw);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        MIO_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (state !== 4'd0 || obs_cw !== 22'(ctrl_for(0, Inst, 1'b0))) begin
            n_bad++;
            $display("FAIL reset_mid_after: state=%0d cw=%h, expected state=0 cw=%h",
                     state, obs_cw, 22'(ctrl_for(0, Inst, 1'b0)));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; Inst = '0; zero = 1'b0; overflow = 1'b0; MIO_ready = 1'b0;
        test_reset();
        test_lw_stall();
        test_branch();
        test_jumps();
        test_overflow();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multicycle control FSM that sequences the 32-bit MIPS multicycle datapath (PC/IR/DR/ALUOut registers, register file, ALU, sign-extender).
- Decodes IR opcode/funct and drives every datapath mux/enable each cycle.
- Handles memory wait states via MIO_ready and flags illegal instructions.
- Sits between the datapath and the memory/IO bus in the SoC CPU core.

Parameters:
- RESET_STATE, 4'd0, state code loaded on reset (IF); must remain 0.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- Inst  in  32  IR output; uses [31:26] opcode and [5:0] funct
- zero  in  1  ALU zero (informational; branch resolution happens in datapath)
- overflow  in  1  ALU signed overflow, combinational
- MIO_ready  in  1  memory/IO ready; 0 = stall current memory state
- IorD, IRWrite, RegWrite, ALUSrcA, PCWrite  out  1  datapath controls
- RegDst, MemtoReg, ALUSrcB, PCSource, Branch  out  2  datapath controls
- ALU_operation  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 100 NOR, 011 XOR
- MemRead, MemWrite  out  1  bus strobes
- state  out  4  current state code (debug)
- illegal  out  1  one-cycle pulse on undecodable instruction
- ovf_trap  out  1  see Optional Feature

Behaviour:
- Moore FSM; outputs decode from state. Any control not listed for a state is 0.
- Reset: while reset=1, all outputs are 0. On the clock edge, state becomes 0 (IF).
- Unused code 15 transitions to IF.
- States (code: outputs -> next):
  - 0 IF: IorD=0, MemRead=1, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ADD, PCSource=00, PCWrite=1. Next: ID if MIO_ready, else stay in IF (IRWrite and PCWrite stay asserted; the datapath gates PC).
  - 1 ID: ALUSrcA=0, ALUSrcB=11, ADD (ALUOut = branch target). Next by opcode: lw/sw -> MA; R-type -> REX (jr funct 001000 -> JR); beq/bne -> BR; j -> J; jal -> JAL; addi/slti/andi/ori/xori -> IEX; lui -> LUI; other -> IF with illegal=1 for that cycle. Unknown R funct is also illegal.
  - 2 MA: ALUSrcA=1, ALUSrcB=10, ADD. Next: MRD for lw, MWR for sw.
  - 3 MRD: MA ALU controls held (ALUOut reloads every cycle), IorD=1, MemRead=1. Next: LWB if MIO_ready, else stay.
  - 4 LWB: RegDst=00, MemtoReg=01, RegWrite=1. Next: IF.
  - 5 MWR: MA ALU controls held, IorD=1, MemWrite=1. Next: IF if MIO_ready, else stay.
  - 6 REX: ALUSrcA=1, ALUSrcB=00, ALU op from funct: add/addu ADD, sub/subu SUB, and AND, or OR, xor XOR, nor NOR, slt SLT. Next: RWB.
  - 7 RWB: RegDst=01, MemtoReg=00, RegWrite=1. REX ALU controls held. Next: IF.
  - 8 BR: ALUSrcA=1, ALUSrcB=00, SUB, PCSource=01; Branch=01 for beq, 10 for bne. Next: IF.
  - 9 J: PCSource=10, PCWrite=1. Next: IF.
  - 10 JAL: PCSource=10, PCWrite=1, RegDst=10, MemtoReg=11, RegWrite=1. $ra receives PC+4 at the same edge the PC updates. Next: IF.
  - 11 JR: ALUSrcA=1, ALUSrcB=00 (rt=$0), ADD, PCSource=00, PCWrite=1. Next: IF.
  - 12 IEX: ALUSrcA=1, ALUSrcB=10; addi ADD, slti SLT, andi AND, ori OR, xori XOR. Immediates are sign-extended by the datapath. Next: IWB.
  - 13 IWB: RegDst=00, MemtoReg=00, RegWrite=1, IEX ALU controls held. Next: IF.
  - 14 LUI: RegDst=00, MemtoReg=10, RegWrite=1. Next: IF.
- CPI: lw 5, sw 4, R/I-type 4, branch 3, j/jal/jr/lui 3, plus stall cycles.
- Reset asserted mid-instruction aborts at the next edge; no partial write completes after reset rises.

Optional Feature:
- Macro: MC_CTRL_OVF_TRAP_EN.
- Defined:
  - A 1-bit register latches overflow at the end of REX (add/sub only) or IEX (addi only).
  - In RWB/IWB with the latch set, RegWrite=0 and ovf_trap=1 for that cycle; the latch clears on the exit to IF and on reset.
- Undefined: ovf_trap is tied to 0 and overflow is ignored.

Test Plan:
- Reset held 2 cycles, release with MIO_ready=1 -> all outputs 0 during reset; state=0 with PCWrite=1, IRWrite=1 on the first cycle after release.
- lw (opcode 100011) with MIO_ready low 3 cycles in MRD -> state sequence 0,1,2,3,3,3,3,4,0; RegWrite=1 only in state 4 with MemtoReg=01.
- beq with zero=1, then bne -> BR state shows Branch=01 then 10, ALU_operation=110, PCSource=01; 3 cycles each.
- jal -> state 10 with RegDst=10, MemtoReg=11, RegWrite=1, PCSource=10, PCWrite=1 in a single cycle.
- add $3,$1,$2 with 0x7FFFFFFF+1: with macro -> ovf_trap=1 and RegWrite=0 in RWB; without macro -> RegWrite=1 and ovf_trap=0.
- Opcode 111111 -> illegal=1 for one cycle in ID, next state 0, no RegWrite/MemWrite asserted.
